vga_timing_gen: RTL

//  Downstream consumer of the divided pixel clock (25 MHz square wave at 100 MHz clk_in).

---
 rtl/vga_timing_gen_pkg.sv | 31 +++
 rtl/vga_timing_gen_pix_edge_det.sv | 28 ++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults (640x480@60 porches/sync) and small helpers used by the
// timing generator and by the renderer.
package vga_timing_gen_pkg;

  // Default 640x480@60 geometry, in pixels / lines.
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam bit          VGA_HS_POL   = 1'b0;
  localparam bit          VGA_VS_POL   = 1'b0;
  localparam int unsigned VGA_CNT_W    = 10;
  localparam int unsigned VGA_FRAME_W  = 8;

  // Registered per-pixel decode that must stay aligned with the coordinates.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // Drive the active polarity while inside the sync window, the idle level otherwise.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_edge_det.sv
// Pixel-clock rising-edge detector. pix_clk is sampled as data on clk_in; rise is a
// combinational pulse for the clk_in cycle in which pix_clk is first seen high.
// Ports:
//   clk_in  - system clock
//   reset   - asynchronous, active-high
//   pix_clk - divided pixel clock, synchronous to clk_in
//   rise    - high for one clk_in cycle on each pix_clk rising edge
module vga_timing_gen_pix_edge_det (
  input  logic clk_in,
  input  logic reset,
  input  logic pix_clk,
  output logic rise
);

  logic pix_d;

  // Reset to 1 so a pix_clk already high when reset drops is not taken as an edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pix_d <= 1'b1;
    end else begin
      pix_d <= pix_clk;
    end
  end

  assign rise = pix_clk & ~pix_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator. Detects pixel-clock rising edges on clk_in and runs the
// horizontal/vertical counters, producing registered sync, blanking and coordinates.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the frame_cnt output.
// Ports:
//   clk_in      - system clock (100 MHz)
//   reset       - asynchronous, active-high
//   enable      - 1 advances on pixel edges, 0 freezes counters and pulses
//   pix_clk     - divided pixel clock, used as data
//   hsync/vsync - registered syncs, polarity set by HS_POL/VS_POL
//   video_on    - registered, high inside the visible area
//   x, y        - pixel coordinates
//   pix_tick    - one-cycle pulse in the cycle after each counter advance
//   frame_start - one-cycle pulse with pix_tick when (x,y) becomes (0,0)
//   frame_cnt   - frames started, wrapping (VGA_TIMING_FRAME_CNT_EN only)
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_POL   = VGA_HS_POL,
  parameter bit          VS_POL   = VGA_VS_POL,
  parameter int unsigned CNT_W    = VGA_CNT_W
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  parameter int unsigned FRAME_W  = VGA_FRAME_W
`endif
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             pix_clk,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             pix_tick,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic             rise;
  logic             tick;
  logic [CNT_W-1:0] x_q, y_q, x_nxt, y_nxt;
  sync_t            sync_q, sync_nxt;
  logic             pix_tick_q, frame_start_q;
  logic             wrap_to_origin;

  vga_timing_gen_pix_edge_det u_edge_det (
    .clk_in  (clk_in),
    .reset   (reset),
    .pix_clk (pix_clk),
    .rise    (rise)
  );

  assign tick = rise & enable;

  // Position after one advance, plus the decode of that position. Decoding the next
  // value lets the syncs register on the same edge as the coordinates.
  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end else begin
      x_nxt = x_q + 1'b1;
    end

    sync_nxt.hsync    = sync_level((x_nxt >= HS_START) && (x_nxt <= HS_END), HS_POL);
    sync_nxt.vsync    = sync_level((y_nxt >= VS_START) && (y_nxt <= VS_END), VS_POL);
    sync_nxt.video_on = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  assign wrap_to_origin = (x_nxt == '0) && (y_nxt == '0);

  // Reset parks on the last blanking pixel so the first edge lands on (0,0).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      sync_q        <= '{hsync: ~HS_POL, vsync: ~VS_POL, video_on: 1'b0};
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_tick_q    <= tick;
      frame_start_q <= tick & wrap_to_origin;
      if (tick) begin
        x_q    <= x_nxt;
        y_q    <= y_nxt;
        sync_q <= sync_nxt;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q;

  // Counts on the same edge that raises frame_start.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (tick && wrap_to_origin) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = sync_q.hsync;
  assign vsync       = sync_q.vsync;
  assign video_on    = sync_q.video_on;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;

endmodule
